rsa256_uart_wrapper: RTL and testbench
======================================

# rsa256_uart_wrapper

Avalon-MM master that bridges the RS-232 UART core to the RSA-256 decryption core. It polls the UART and receives the 256-bit modulus n, then the 256-bit private key d, then a stream of 256-bit ciphertext blocks, all MSB byte first. For each block it starts the core, waits for completion, and transmits the plaintext back over the UART. It sits directly upstream of and downstream from the RSA core and is the only UART client in lab2.

## Interface
- Parameters:
- `ADDR_RX`, default 0: byte address of the UART RX data register.
- `ADDR_TX`, default 4: byte address of the UART TX data register.
- `ADDR_STATUS`, default 8: byte address of the UART status register.
- `BIT_TRDY`, default 6: status bit meaning TX ready.
- `BIT_RRDY`, default 7: status bit meaning RX ready.
- Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `avm_address`, out, 5: Avalon byte address.
- `avm_read`, out, 1: Avalon read request.
- `avm_readdata`, in, 32: Avalon read data; only bits [7:0] carry data bytes.
- `avm_write`, out, 1: Avalon write request.
- `avm_writedata`, out, 32: Avalon write data, as {24'b0, byte}.
- `avm_waitrequest`, in, 1: Avalon stall.
- `o_rsa_start`, out, 1: one-cycle start pulse to the core.
- `o_rsa_a`, out, 256: ciphertext block.
- `o_rsa_d`, out, 256: private key.
- `o_rsa_n`, out, 256: modulus.
- `i_rsa_dec`, in, 256: plaintext result from the core.
- `i_rsa_finished`, in, 1: core done pulse.

## Operation
- Phase register, in order: KEY_N, then KEY_D, then CIPHER. After KEY_D completes, the phase stays at CIPHER until reset. Keys are loaded once per reset.
- States:
- S_QUERY_RX: read ADDR_STATUS. When the transaction completes with RRDY=1, go to S_READ. Otherwise re-issue the read.
- S_READ: read ADDR_RX. On completion, shift the byte into the LSB of the phase's 256-bit register (the register shifts left by 8) and increment the byte counter (6 bits).
  - At count 32: clear the counter. In phases KEY_N and KEY_D, advance the phase and return to S_QUERY_RX. In phase CIPHER, go to S_START.
  - Below count 32: return to S_QUERY_RX.
- S_START: assert o_rsa_start for exactly one cycle, then go to S_WAIT_CALC.
- S_WAIT_CALC: on i_rsa_finished, latch i_rsa_dec into the output shift register and go to S_QUERY_TX.
- S_QUERY_TX: read ADDR_STATUS. When the transaction completes with TRDY=1, go to S_WRITE. Otherwise re-issue the read.
- S_WRITE: write the output register's current top byte to ADDR_TX. On completion, shift the register left by 8 and increment the counter.
  - When the last byte is sent: clear the counter and return to S_QUERY_RX with the phase still CIPHER.
  - Otherwise: return to S_QUERY_TX.
- Bytes sent per block: 31 by default, starting from bits [247:240], because the plaintext is less than n and its top byte is dropped.
- Avalon rules:
  - avm_read and avm_write are never asserted together.
  - Address, read/write and writedata are held stable while avm_waitrequest=1.
  - A transaction completes on the first cycle the request is high with avm_waitrequest=0. readdata is sampled in that cycle.
- o_rsa_a, o_rsa_d and o_rsa_n are driven directly from the shift registers. They stay stable from S_START until the next S_READ in the CIPHER phase.
- i_rsa_finished is ignored outside S_WAIT_CALC.

## Timing
- Reset values of outputs:
  - All Avalon outputs are 0, with avm_address = ADDR_STATUS.
  - o_rsa_start = 0.
  - o_rsa_a, o_rsa_d and o_rsa_n are 0.
  - State is S_QUERY_RX, phase is KEY_N, counter is 0.
- Reset asserted mid-operation (including during S_WAIT_CALC or during an Avalon stall) aborts the operation. The outstanding request is dropped immediately and the keys are lost.
- With no stalls and the UART always ready:
  - Each received byte takes 2 cycles (status read + data read).
  - Each transmitted byte takes 2 cycles.
  - Block turnaround is 64 + 1 + T_core + 62 cycles.
- o_rsa_start rises exactly 1 cycle after the 32nd ciphertext byte's read completes.

## Configuration
- `RSA_WRAP_FULL_OUTPUT_EN`:
  - Defined: all 32 plaintext bytes are sent, starting from bits [255:248].
  - Undefined: 31 bytes are sent, starting from bits [247:240].

## Structure
- Package `rsa_wrap_pkg` holds:
  - the state enum;
  - the phase enum;
  - the byte-count constants (32, 31/32);
  - the default register addresses and bit indices.
- Sub-module `rsa_avm_txn` is a single-transaction Avalon master. It takes a request, the direction, the address and the write byte, and returns a done pulse and the read byte. It owns all waitrequest holding.
- The top level holds the FSM, the phase and counter logic, and the three 256-bit shift registers plus the output shift register.

## Test plan
- Key load: UART model supplies n = 0xCA3586E7…, then d; the model keeps RRDY=1. Required: o_rsa_n and o_rsa_d match byte-exact with the MSB byte first, and no o_rsa_start occurs until 32 cipher bytes have been received.
- Single block: a = 32 bytes of 0x01 and the core model returns dec = 0x00 || 0x11…11. Required: exactly one start pulse and exactly 31 TX writes, each with writedata = 0x00000011.
- Stall: random avm_waitrequest (50%) and RRDY/TRDY low for 1–20 polls. Required: the byte stream is unchanged, request signals are held during stalls, and read/write are never asserted together.
- Multi-block: 3 cipher blocks are sent back to back. Required: 3 starts and 93 TX bytes in order; keys are not reloaded.
- Reset mid-wait: i_rst is asserted in S_WAIT_CALC. Required: next cycle all outputs are at reset values and the phase is KEY_N; a late i_rsa_finished is ignored.
- With `RSA_WRAP_FULL_OUTPUT_EN` defined: single block. Required: 32 TX bytes, and the first byte equals dec[255:248].

Source files
------------

// File: rtl/rsa_wrap_pkg.sv
// rsa_wrap_pkg: shared FSM, phase and byte-count constants for rsa256_uart_wrapper.
// RSA_WRAP_FULL_OUTPUT_EN selects sending all 32 plaintext bytes instead of 31.
package rsa_wrap_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_QUERY_RX = 3'd0, S_READ = 3'd1, S_START = 3'd2,
                     S_WAIT_CALC = 3'd3, S_QUERY_TX = 3'd4, S_WRITE = 3'd5;
  typedef enum logic [1:0] {KEY_N, KEY_D, CIPHER} phase_t;
  localparam logic [5:0] RX_BYTES = 6'd32;
`ifdef RSA_WRAP_FULL_OUTPUT_EN
  localparam logic [5:0] TX_BYTES = 6'd32;
  localparam int TX_SKIP = 0;
`else
  localparam logic [5:0] TX_BYTES = 6'd31;
  localparam int TX_SKIP = 8;
`endif
  localparam logic [4:0] DEF_ADDR_RX = 5'd0, DEF_ADDR_TX = 5'd4, DEF_ADDR_STATUS = 5'd8;
  localparam logic [2:0] DEF_BIT_TRDY = 3'd6, DEF_BIT_RRDY = 3'd7;
endpackage

// File: rtl/rsa_avm_txn.sv
// rsa_avm_txn: single-transaction Avalon master; the next request is registered as the current one completes.
module rsa_avm_txn
  import rsa_wrap_pkg::*;
#(
  parameter logic [4:0] RST_ADDR = DEF_ADDR_STATUS
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        req,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [7:0]  wbyte,
  output logic        done,
  output logic [7:0]  rbyte,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);
  logic load;
  logic unused_rd;
  assign done = (avm_read | avm_write) & ~avm_waitrequest;
  assign load = ~(avm_read | avm_write) | done;
  assign rbyte = avm_readdata[7:0];
  assign unused_rd = ^avm_readdata[31:8];
  // a stalled request keeps every Avalon output frozen because load stays low
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      avm_address <= RST_ADDR;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      avm_writedata <= 32'b0;
    end else if (load) begin
      avm_address <= req ? addr : avm_address;
      avm_read <= req & ~wr;
      avm_write <= req & wr;
      avm_writedata <= req & wr ? {24'b0, wbyte} : 32'b0;
    end
endmodule

// File: rtl/rsa256_uart_wrapper.sv
// rsa256_uart_wrapper: polls the UART for n, d and cipher blocks, runs the RSA core, returns plaintext.
// RSA_WRAP_FULL_OUTPUT_EN (via rsa_wrap_pkg) sends all 32 plaintext bytes.
module rsa256_uart_wrapper
  import rsa_wrap_pkg::*;
#(
  parameter logic [4:0] ADDR_RX = DEF_ADDR_RX,
  parameter logic [4:0] ADDR_TX = DEF_ADDR_TX,
  parameter logic [4:0] ADDR_STATUS = DEF_ADDR_STATUS,
  parameter logic [2:0] BIT_TRDY = DEF_BIT_TRDY,
  parameter logic [2:0] BIT_RRDY = DEF_BIT_RRDY
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_rsa_start,
  output logic [255:0] o_rsa_a,
  output logic [255:0] o_rsa_d,
  output logic [255:0] o_rsa_n,
  input  logic [255:0] i_rsa_dec,
  input  logic         i_rsa_finished
);
  state_t state, state_n;
  phase_t phase;
  logic [5:0] cnt;
  logic [255:0] n_sr, d_sr, a_sr, out_sr;
  logic done, req, wr, last_rx, last_tx, rx_done, tx_done;
  logic [7:0] rbyte;
  logic [4:0] addr;
  assign last_rx = cnt == RX_BYTES - 6'd1;
  assign last_tx = cnt == TX_BYTES - 6'd1;
  assign rx_done = state == S_READ && done;
  assign tx_done = state == S_WRITE && done;
  always_comb begin
    state_n = state;
    case (state)
      S_QUERY_RX:  state_n = done && rbyte[BIT_RRDY] ? S_READ : S_QUERY_RX;
      S_READ:      state_n = !done ? S_READ : last_rx && phase == CIPHER ? S_START : S_QUERY_RX;
      S_START:     state_n = S_WAIT_CALC;
      S_WAIT_CALC: state_n = i_rsa_finished ? S_QUERY_TX : S_WAIT_CALC;
      S_QUERY_TX:  state_n = done && rbyte[BIT_TRDY] ? S_WRITE : S_QUERY_TX;
      S_WRITE:     state_n = !done ? S_WRITE : last_tx ? S_QUERY_RX : S_QUERY_TX;
      default:     state_n = S_QUERY_RX;
    endcase
  end
  // requests are derived from the next state so back-to-back transactions cost one cycle each
  assign req = state_n != S_START && state_n != S_WAIT_CALC;
  assign wr = state_n == S_WRITE;
  assign addr = state_n == S_READ ? ADDR_RX : state_n == S_WRITE ? ADDR_TX : ADDR_STATUS;
  rsa_avm_txn #(.RST_ADDR(ADDR_STATUS)) u_txn (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .req(req),
    .wr(wr),
    .addr(addr),
    .wbyte(out_sr[255:248]),
    .done(done),
    .rbyte(rbyte),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= S_QUERY_RX;
      phase <= KEY_N;
      cnt <= 6'd0;
      n_sr <= 256'b0;
      d_sr <= 256'b0;
      a_sr <= 256'b0;
      out_sr <= 256'b0;
    end else begin
      state <= state_n;
      if (rx_done) begin
        cnt <= last_rx ? 6'd0 : cnt + 6'd1;
        phase <= !last_rx ? phase : phase == KEY_N ? KEY_D : CIPHER;
        n_sr <= phase == KEY_N ? {n_sr[247:0], rbyte} : n_sr;
        d_sr <= phase == KEY_D ? {d_sr[247:0], rbyte} : d_sr;
        a_sr <= phase == CIPHER ? {a_sr[247:0], rbyte} : a_sr;
      end
      if (state == S_WAIT_CALC && i_rsa_finished)
        out_sr <= i_rsa_dec << TX_SKIP;
      if (tx_done) begin
        out_sr <= {out_sr[247:0], 8'b0};
        cnt <= last_tx ? 6'd0 : cnt + 6'd1;
      end
    end
  assign o_rsa_start = state == S_START;
  assign o_rsa_a = a_sr;
  assign o_rsa_d = d_sr;
  assign o_rsa_n = n_sr;
endmodule

// File: tb/tb_rsa256_uart_wrapper.sv
// tb_rsa256_uart_wrapper: UART + RSA core model with a TX byte scoreboard for rsa256_uart_wrapper.
module tb_rsa256_uart_wrapper;
`ifdef RSA_WRAP_FULL_OUTPUT_EN
  localparam int TXB = 32, SKIPB = 0;
`else
  localparam int TXB = 31, SKIPB = 1;
`endif
  logic i_clk = 0, i_rst = 0;
  logic [4:0] avm_address;
  logic avm_read, avm_write, avm_waitrequest = 0, o_rsa_start, i_rsa_finished = 0;
  logic [31:0] avm_readdata = 0, avm_writedata;
  logic [255:0] o_rsa_a, o_rsa_d, o_rsa_n, i_rsa_dec = 0;
  int checks = 0, failures = 0;
  int cyc = 0, last_rd_cyc = 0, rx_cnt = 0, tx_cnt = 0, starts = 0, kblk = 0;
  int fin_cnt = 0, core_lat = 5, rx_gap = 0, tx_gap = 0;
  bit stall_en = 0, prev_stall = 0, prev_start = 0, wreq;
  logic [4:0] p_addr;
  logic p_rd, p_wr;
  logic [31:0] p_wd;
  logic [255:0] exp_n, exp_d, cur_dec;
  logic [7:0] rx_q[$], exp_q[$];
  logic [255:0] exp_a_q[$], dec_q[$];

  rsa256_uart_wrapper dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .o_rsa_start(o_rsa_start), .o_rsa_a(o_rsa_a), .o_rsa_d(o_rsa_d), .o_rsa_n(o_rsa_n),
    .i_rsa_dec(i_rsa_dec), .i_rsa_finished(i_rsa_finished)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int gap();
    return stall_en && $urandom_range(0, 1) == 1 ? int'($urandom_range(1, 20)) : 0;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(negedge i_clk);
    #2;
  endtask

  task automatic push_bytes(input logic [255:0] v);
    for (int i = 0; i < 32; i++) rx_q.push_back(v[255-8*i -: 8]);
  endtask

  task automatic send_block(input logic [255:0] a, input logic [255:0] dec);
    push_bytes(a);
    exp_a_q.push_back(a);
    dec_q.push_back(dec);
    for (int i = 0; i < TXB; i++) exp_q.push_back(dec[255-8*(i+SKIPB) -: 8]);
  endtask

  task automatic load_keys(input logic [255:0] n, input logic [255:0] d);
    exp_n = n;
    exp_d = d;
    push_bytes(n);
    push_bytes(d);
  endtask

  task automatic check_reset();
    check("rst_addr", avm_address, 8);
    check("rst_read", avm_read, 0);
    check("rst_write", avm_write, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_start", o_rsa_start, 0);
    check("rst_a", o_rsa_a, 0);
    check("rst_d", o_rsa_d, 0);
    check("rst_n", o_rsa_n, 0);
  endtask

  task automatic do_reset();
    i_rst = 1;
    #1;
    check_reset();
    rx_q.delete();
    exp_q.delete();
    exp_a_q.delete();
    dec_q.delete();
    kblk = 0;
    rx_cnt = 0;
    rx_gap = 0;
    tx_gap = 0;
    repeat (2) step();
    check_reset();
    i_rst = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || dec_q.size() != 0 || rx_q.size() != 0 || fin_cnt != 0) && n < budget) begin
      step();
      n++;
    end
    check("timeout", n < budget, 1);
    repeat (4) step();
  endtask

  // UART and RSA core model, evaluated once per cycle away from the active edge
  initial forever begin
    @(negedge i_clk);
    cyc++;
    i_rsa_finished = 0;
    if (fin_cnt > 0) begin
      fin_cnt--;
      if (fin_cnt == 0) begin
        i_rsa_finished = 1;
        i_rsa_dec = cur_dec;
      end
    end
    if (i_rst) begin
      prev_stall = 0;
      prev_start = 0;
      continue;
    end
    if (prev_start) check("start_pulse", o_rsa_start, 0);
    else if (o_rsa_start) begin
      starts++;
      kblk++;
      check("start_lat", cyc - last_rd_cyc, 1);
      check("rx_before_start", rx_cnt, 64 + 32 * kblk);
      check("key_n", o_rsa_n, exp_n);
      check("key_d", o_rsa_d, exp_d);
      check("a_avail", exp_a_q.size() != 0, 1);
      if (exp_a_q.size() != 0) check("cipher_a", o_rsa_a, exp_a_q.pop_front());
      cur_dec = dec_q.size() != 0 ? dec_q.pop_front() : 256'b0;
      fin_cnt = core_lat;
    end
    prev_start = o_rsa_start;
    if (prev_stall) begin
      check("hold_addr", avm_address, p_addr);
      check("hold_read", avm_read, p_rd);
      check("hold_write", avm_write, p_wr);
      check("hold_wdata", avm_writedata, p_wd);
    end
    check("rw_excl", avm_read & avm_write, 0);
    wreq = stall_en ? $urandom_range(0, 1) == 1 : 0;
    avm_waitrequest = wreq;
    avm_readdata = 0;
    if (avm_address == 8) begin
      avm_readdata[7] = rx_q.size() != 0 && rx_gap == 0;
      avm_readdata[6] = tx_gap == 0;
    end else if (avm_address == 0 && rx_q.size() != 0) avm_readdata[7:0] = rx_q[0];
    if ((avm_read || avm_write) && !wreq) begin
      if (avm_read && avm_address == 8) begin
        if (rx_gap > 0) rx_gap--;
        if (tx_gap > 0) tx_gap--;
      end else if (avm_read) begin
        check("rx_addr", avm_address, 0);
        check("rx_avail", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        rx_cnt++;
        last_rd_cyc = cyc;
        rx_gap = gap();
      end else begin
        check("tx_addr", avm_address, 4);
        check("tx_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_byte", avm_writedata, {24'b0, exp_q.pop_front()});
        tx_cnt++;
        tx_gap = gap();
      end
    end
    prev_stall = (avm_read || avm_write) && wreq;
    p_addr = avm_address;
    p_rd = avm_read;
    p_wr = avm_write;
    p_wd = avm_writedata;
  end

  initial begin
    int s0, t0, n;
    #3;
    do_reset();
    s0 = starts;
    t0 = tx_cnt;
    load_keys(256'hCA3586E7_1F2E3D4C_5B6A7988_97A6B5C4_D3E2F100_0F1E2D3C_4B5A6978_8796A5B4,
              256'h0123ABCD_89EF4567_FEDCBA98_76543210_0BADF00D_DEADBEEF_C0FFEE11_55AA33CC);
    send_block({32{8'h01}}, {8'h00, {31{8'h11}}});
    wait_done(3000);
    check("single_starts", starts - s0, 1);
    check("single_tx", tx_cnt - t0, TXB);
    s0 = starts;
    t0 = tx_cnt;
    for (int k = 0; k < 3; k++) send_block(rand256(), rand256());
    wait_done(6000);
    check("multi_starts", starts - s0, 3);
    check("multi_tx", tx_cnt - t0, 3 * TXB);
    do_reset();
    stall_en = 1;
    s0 = starts;
    t0 = tx_cnt;
    load_keys(rand256(), rand256());
    send_block(rand256(), rand256());
    send_block(rand256(), rand256());
    wait_done(30000);
    check("stall_starts", starts - s0, 2);
    check("stall_tx", tx_cnt - t0, 2 * TXB);
    stall_en = 0;
    do_reset();
    core_lat = 30;
    s0 = starts;
    t0 = tx_cnt;
    load_keys(rand256(), rand256());
    send_block(rand256(), rand256());
    n = 0;
    while (starts == s0 && n < 2000) begin
      step();
      n++;
    end
    check("wait_start", n < 2000, 1);
    repeat (3) step();
    do_reset();
    repeat (40) step();
    check("late_fin_tx", tx_cnt - t0, 0);
    check("late_fin_start", starts - s0, 1);
    check("late_fin_idle", fin_cnt, 0);
    core_lat = 5;
    s0 = starts;
    t0 = tx_cnt;
    load_keys(rand256(), rand256());
    send_block(rand256(), rand256());
    wait_done(3000);
    check("reload_starts", starts - s0, 1);
    check("reload_tx", tx_cnt - t0, TXB);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
